// File: rtl/sdram_tester_pkg.sv
// rtl/sdram_tester_pkg.sv - shared types and defaults for the SDRAM burst tester
// Purpose: state encoding, default geometry and counter widths.
// Ports:   none (package).
package sdram_tester_pkg;

  localparam int BURST_LEN_DEF = 256;
  localparam int ADDR_W_DEF    = 22;
  localparam int DATA_W_DEF    = 16;
  localparam int BCNT_W        = 9;   // Avalon burstcount width, holds 1..256
  localparam int NBURST_W      = 14;  // num_bursts width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sdram_tester_checker.sv
// rtl/sdram_tester_checker.sv - read-beat compare with saturating error count
// Purpose: compares each read beat against its expected pattern, counts
//          mismatches (saturating at 0xFFFF) and latches the first bad address.
// Ports:   clk/rst_n      clock, asynchronous active-low reset
//          clear          zero the results (accepted start)
//          beat_valid     a read beat belonging to the current burst
//          rdata/expected observed and reference word
//          beat_addr      word address of the beat
//          err_count      mismatch count
//          first_err_addr address of the first mismatch
module sdram_tester_checker
  import sdram_tester_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] expected,
  input  logic [ADDR_W-1:0] beat_addr,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic [15:0]       err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic              mismatch;

  always_comb begin
    mismatch         = beat_valid && (rdata != expected);
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    if (clear) begin
      err_count_d      = '0;
      first_err_addr_d = '0;
    end else if (mismatch) begin
      // The count only returns to zero on clear, so zero means "no error yet".
      if (err_count_q == 16'h0000) first_err_addr_d = beat_addr;
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q      <= '0;
      first_err_addr_q <= '0;
    end else begin
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
    end
  end

  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: rtl/sdram_burst_tester.sv
// rtl/sdram_burst_tester.sv - Avalon-MM burst write/read-back memory tester
// Purpose: writes num_bursts bursts of an address^seed pattern starting at
//          base_addr, reads them back one burst at a time and reports errors.
// Ports:   clk_clk, reset_reset_n   clock, asynchronous active-low reset
//          start/seed/base_addr/num_bursts   test request and parameters
//          busy/done/pass/err_count/first_err_addr   status and results
//          avm_*                    Avalon-MM burst master to the SDRAM slave
module sdram_burst_tester
  import sdram_tester_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   seed,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [NBURST_W-1:0] num_bursts,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [BCNT_W-1:0]   avm_burstcount,
  output logic                avm_write,
  output logic                avm_read,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST_LEN - 1);
  localparam logic [BCNT_W-1:0] BCOUNT    = BCNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BL_STEP   = ADDR_W'(BURST_LEN);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [NBURST_W-1:0] burst_q, burst_d;
  logic [NBURST_W-1:0] nb_q, nb_d;
  logic [BCNT_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0]   seed_q, seed_d;

  logic                accept_start;
  logic                last_burst;
  logic [ADDR_W-1:0]   beat_addr;
  logic [DATA_W-1:0]   pattern;
  logic                cmd_active;

  assign accept_start = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_burst   = (burst_q == nb_q - NBURST_W'(1));
  assign beat_addr    = addr_q + ADDR_W'(beat_q);

  // Pattern word for the current beat; narrow address buses are zero-extended.
  if (ADDR_W >= DATA_W) begin : g_pat_trunc
    assign pattern = beat_addr[DATA_W-1:0] ^ seed_q;
  end else begin : g_pat_ext
    assign pattern = {{(DATA_W-ADDR_W){1'b0}}, beat_addr} ^ seed_q;
  end

  // State register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      burst_q <= '0;
      nb_q    <= '0;
      beat_q  <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      burst_q <= burst_d;
      nb_q    <= nb_d;
      beat_q  <= beat_d;
      seed_q  <= seed_d;
    end
  end

  // Next state and counters
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    burst_d = burst_q;
    nb_d    = nb_q;
    beat_d  = beat_q;
    seed_d  = seed_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_start) begin
          addr_d  = base_addr;
          base_d  = base_addr;
          nb_d    = num_bursts;
          seed_d  = seed;
          burst_d = '0;
          beat_d  = '0;
          state_d = (num_bursts == '0) ? ST_DONE : ST_WR;
        end
      end
      ST_WR: begin
        if (!avm_waitrequest) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (last_burst) begin
              // Bursts run back to back; the read-back restarts from the base.
              addr_d  = base_q;
              burst_d = '0;
              state_d = ST_RD_CMD;
            end else begin
              addr_d  = addr_q + BL_STEP;
              burst_d = burst_q + NBURST_W'(1);
            end
          end else begin
            beat_d = beat_q + BCNT_W'(1);
          end
        end
      end
      ST_RD_CMD: begin
        if (!avm_waitrequest) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (avm_readdatavalid) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (last_burst) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + BL_STEP;
              burst_d = burst_q + NBURST_W'(1);
              state_d = ST_RD_CMD;
            end
          end else begin
            beat_d = beat_q + BCNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state so reset clears them at once.
  always_comb begin
    avm_write      = (state_q == ST_WR);
    avm_read       = (state_q == ST_RD_CMD);
    cmd_active     = avm_write || avm_read;
    avm_address    = cmd_active ? addr_q : '0;
    avm_burstcount = cmd_active ? BCOUNT : '0;
    avm_byteenable = cmd_active ? '1 : '0;
    avm_writedata  = avm_write ? pattern : '0;
    busy           = (state_q == ST_WR) || (state_q == ST_RD_CMD) || (state_q == ST_RD_DATA);
    done           = (state_q == ST_DONE);
    pass           = done && (err_count == 16'h0000);
  end

  sdram_tester_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_checker (
    .clk            (clk_clk),
    .rst_n          (reset_reset_n),
    .clear          (accept_start),
    .beat_valid     ((state_q == ST_RD_DATA) && avm_readdatavalid),
    .rdata          (avm_readdata),
    .expected       (pattern),
    .beat_addr      (beat_addr),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: doc/sdram_burst_tester.md
SDRAM_BURST_TESTER -- requirements
Module: sdram_burst_tester

Interface
REQ-001 Parameter BURST_LEN, 256, words per Avalon burst, 1..256, power of two.
REQ-002 Parameter ADDR_W, 22, Avalon word-address width.
REQ-003 Parameter DATA_W, 16, Avalon data width; byteenable width is DATA_W/8.
REQ-004 clk_clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to begin a test pass.
REQ-007 seed  in  DATA_W  pattern seed, sampled on accepted start.
REQ-008 base_addr  in  ADDR_W  first word address, sampled on accepted start.
REQ-009 num_bursts  in  14  burst count per phase, sampled on accepted start.
REQ-010 busy  out  1  high from accepted start until DONE is entered.
REQ-011 done  out  1  high in DONE; cleared by the next accepted start.
REQ-012 pass  out  1  high in DONE when err_count is 0.
REQ-013 err_count  out  16  mismatching read beats, saturating.
REQ-014 first_err_addr  out  ADDR_W  word address of the first mismatch.
REQ-015 avm_address, avm_burstcount(9), avm_write, avm_read, avm_writedata, avm_byteenable  out  Avalon-MM burst master command, driving the SDRAM controller user slave.
REQ-016 avm_waitrequest, avm_readdata(DATA_W), avm_readdatavalid  in  slave responses.

Function
REQ-017 The FSM SHALL have states IDLE, WR, RD_CMD, RD_DATA and DONE.
REQ-018 start is accepted in IDLE or DONE only; in other states it is ignored.
REQ-019 On accepted start: go to WR, load addr from base_addr, zero burst and beat counters, err_count and first_err_addr, clear done.
REQ-020 If num_bursts is 0, go straight to DONE with pass=1; no bus traffic occurs.
REQ-021 Pattern: word at address A is (A[DATA_W-1:0] XOR seed), or the zero-extended value if ADDR_W < DATA_W.
REQ-022 WR: avm_write is held high; avm_address is the burst start address and avm_burstcount is BURST_LEN, both constant for the whole burst.
REQ-023 A write beat is accepted when avm_write and not avm_waitrequest; writedata advances only on acceptance.
REQ-024 After beat BURST_LEN-1: advance addr by BURST_LEN (mod 2^ADDR_W); after the last burst, reset addr and counters and go to RD_CMD.
REQ-025 Between write bursts, avm_write SHALL stay high with no idle cycle.
REQ-026 RD_CMD: avm_read high, address and burstcount as for writes; on not avm_waitrequest go to RD_DATA and drop avm_read.
REQ-027 Exactly one read burst is outstanding at a time.
REQ-028 RD_DATA: each avm_readdatavalid beat is compared with the pattern for addr+beat.
REQ-029 On mismatch, err_count increments and saturates at 0xFFFF; first_err_addr is captured only on the first mismatch.
REQ-030 After beat BURST_LEN-1 of the last burst, go to DONE; otherwise advance addr and return to RD_CMD.
REQ-031 avm_readdatavalid outside RD_DATA SHALL be ignored.
REQ-032 avm_byteenable SHALL be all ones whenever avm_write or avm_read is high.
REQ-033 avm_read and avm_write SHALL never both be high.
REQ-034 DONE: done=1, busy=0, pass=(err_count==0); results are held until the next accepted start.

Reset
REQ-035 Reset SHALL force IDLE with every output 0 (busy, done, pass, err_count, first_err_addr and all avm_* outputs).
REQ-036 Reset asserted mid-burst SHALL drop avm_write and avm_read immediately and asynchronously; no beat state survives reset.

Structure
REQ-037 Package sdram_tester_pkg holds the state enum, BURST_LEN and ADDR_W defaults, and the burst-count width (9).
REQ-038 Sub-module sdram_tester_checker holds the beat compare, saturating err_count and first_err_addr capture; the FSM, counters and pattern logic stay in the top module.

Verification
REQ-039 Zero-wait slave model, base 0x000100, num_bursts=2, seed 0xA5A5 -> 512 write beats then 512 read beats; done=1, pass=1, err_count=0.
REQ-040 Random avm_waitrequest at 50% -> avm_address, avm_burstcount and avm_writedata stay stable while stalled; outcome matches REQ-039.
REQ-041 Model corrupts word 0x000105 and word 0x000180 -> err_count=2, first_err_addr=0x000105, pass=0.
REQ-042 num_bursts=0 -> done within 2 cycles of start, pass=1, no avm_read or avm_write asserted.
REQ-043 base 0x3FFF00, num_bursts=2 -> second burst at 0x000000 (wrap); test passes.
REQ-044 Reset pulsed during the write phase, then start pulsed in WR -> outputs are 0 during reset; the start in WR is ignored; a fresh start after reset runs a full pass.
